// File: rtl/wb_copro_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_copro_pkg : shared constants and types for the coprocessor bus slave
// Rev 1.0
// ----------------------------------------------------------------------------
package wb_copro_pkg;

  localparam logic [2:0] c_REG_OPA    = 3'd0;
  localparam logic [2:0] c_REG_OPB    = 3'd1;
  localparam logic [2:0] c_REG_CMD    = 3'd2;
  localparam logic [2:0] c_REG_STATUS = 3'd3;
  localparam logic [2:0] c_REG_RESULT = 3'd4;
  localparam logic [2:0] c_REG_CTRL   = 3'd5;

  localparam int unsigned c_ST_BUSY    = 0;
  localparam int unsigned c_ST_DONE    = 1;
  localparam int unsigned c_ST_TIMEOUT = 2;
  localparam int unsigned c_ST_FLAGS   = 3;

  localparam int unsigned c_FLAG_NX = 0;
  localparam int unsigned c_FLAG_UF = 1;
  localparam int unsigned c_FLAG_OF = 2;
  localparam int unsigned c_FLAG_DZ = 3;
  localparam int unsigned c_FLAG_NV = 4;

  localparam logic [31:0] c_QNAN     = 32'h7FC0_0000;
  localparam logic [2:0]  c_CTI_INCR = 3'b010;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;
  typedef enum logic [1:0] {RSP_NONE, RSP_ACK, RSP_ERR, RSP_RTY} rsp_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_copro_wdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_copro_wdog : loadable up-counter raising expire_o on its last count
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_copro_wdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == c_LAST);

  // Holds at the last count so a stalled enable can never wrap around.
  always_ff @(posedge clk_i) begin
    if (!rst_i || load_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_copro_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_copro_slave : Wishbone register front-end launching and tracking the FPU
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_copro_slave
  import wb_copro_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned FLAG_W      = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              cp_start_o,
  output logic [OP_W-1:0]   cp_op_o,
  output logic [31:0]       cp_a_o,
  output logic [31:0]       cp_b_o,
  input  logic              cp_done_i,
  input  logic [31:0]       cp_res_i,
  input  logic [FLAG_W-1:0] cp_flags_i,
  output logic              cp_abort_o,
  output logic              irq_o
);

  state_e            state_q, state_d;
  logic [31:0]       opa_q, opb_q, res_q, a_q, b_q, dat_q;
  logic [OP_W-1:0]   op_q;
  logic [FLAG_W-1:0] flags_q;
  logic              done_q, tmo_q, irq_en_q;
  logic              ack_q, err_q, rty_q, rd_res_q;

  logic              w_busy, w_accept, w_launch, w_expire;
  logic [2:0]        w_idx;
  rsp_e              w_rsp;
  logic [31:0]       w_rdata, w_status;
  logic              w_unused;

  assign w_unused = ^{wb_bte_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  assign w_busy   = (state_q == LAUNCH) || (state_q == WAIT);
  assign w_idx    = wb_adr_i[4:2];
  // Incrementing bursts bypass the one-idle-cycle spacing between responses.
  assign w_accept = wb_cyc_i && wb_stb_i &&
                    (!(ack_q || err_q || rty_q) || (wb_cti_i == c_CTI_INCR));

  always_comb begin
    w_rsp    = RSP_ACK;
    w_launch = 1'b0;
    w_rdata  = '0;
    w_status = '0;
    w_status[c_ST_BUSY]              = w_busy;
    w_status[c_ST_DONE]              = done_q;
    w_status[c_ST_TIMEOUT]           = tmo_q;
    w_status[c_ST_FLAGS +: FLAG_W]   = flags_q;
    case (w_idx)
      c_REG_OPA:    w_rdata = opa_q;
      c_REG_OPB:    w_rdata = opb_q;
      c_REG_CMD: begin
        if (wb_we_i) begin
          if (w_busy) w_rsp = RSP_RTY;
          else        w_launch = wb_sel_i[0];
        end
      end
      c_REG_STATUS: begin
        if (wb_we_i) w_rsp = RSP_ERR;
        else         w_rdata = w_status;
      end
      c_REG_RESULT: begin
        if (wb_we_i)     w_rsp = RSP_ERR;
        else if (w_busy) w_rsp = RSP_RTY;
        else             w_rdata = res_q;
      end
      c_REG_CTRL:   w_rdata = {31'b0, irq_en_q};
      default:      w_rsp = RSP_ERR;
    endcase
    if (!w_accept) begin
      w_rsp    = RSP_NONE;
      w_launch = 1'b0;
    end
  end

  wb_copro_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (state_q == LAUNCH),
    .en_i     (state_q == WAIT),
    .expire_o (w_expire)
  );

  always_comb begin
    state_d    = state_q;
    cp_start_o = 1'b0;
    cp_abort_o = 1'b0;
    case (state_q)
      IDLE, DONE: if (w_launch) state_d = LAUNCH;
      LAUNCH: begin
        cp_start_o = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (cp_done_i) begin
          state_d = DONE;
        end else if (w_expire) begin
          cp_abort_o = 1'b1;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dat_q    <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      rd_res_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= (w_rsp == RSP_ACK);
      err_q    <= (w_rsp == RSP_ERR);
      rty_q    <= (w_rsp == RSP_RTY);
      dat_q    <= ((w_rsp == RSP_ACK) && !wb_we_i) ? w_rdata : '0;
      // done drops at the end of the RESULT ack cycle, even if cyc is withdrawn.
      rd_res_q <= (w_rsp == RSP_ACK) && !wb_we_i && (w_idx == c_REG_RESULT);
      if (rd_res_q) done_q <= 1'b0;

      if ((w_rsp == RSP_ACK) && wb_we_i) begin
        case (w_idx)
          c_REG_OPA:  opa_q <= byte_merge(opa_q, wb_dat_i, wb_sel_i);
          c_REG_OPB:  opb_q <= byte_merge(opb_q, wb_dat_i, wb_sel_i);
          c_REG_CTRL: if (wb_sel_i[0]) irq_en_q <= wb_dat_i[0];
          default: ;
        endcase
      end

      if (w_launch) begin
        op_q    <= wb_dat_i[OP_W-1:0];
        a_q     <= opa_q;
        b_q     <= opb_q;
        done_q  <= 1'b0;
        tmo_q   <= 1'b0;
        flags_q <= '0;
      end

      if (state_q == WAIT) begin
        if (cp_done_i) begin
          res_q   <= cp_res_i;
          flags_q <= cp_flags_i;
          done_q  <= 1'b1;
        end else if (w_expire) begin
          res_q              <= c_QNAN;
          tmo_q              <= 1'b1;
          flags_q            <= '0;
          flags_q[c_FLAG_NV] <= 1'b1;
          done_q             <= 1'b1;
        end
      end
    end
  end

  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;
  assign wb_rty_o = rty_q & wb_cyc_i;
  assign wb_dat_o = wb_ack_o ? dat_q : '0;
  assign cp_op_o  = op_q;
  assign cp_a_o   = a_q;
  assign cp_b_o   = b_q;
  assign irq_o    = done_q & irq_en_q;

endmodule
`default_nettype wire
